// File: rtl/spi_pkg.sv
// Shared SPI link definitions used by both the slave and the master.
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int CNT_W     = $clog2(SPI_WIDTH);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous pin with registered rise/fall pulses.
// The chain has no reset so it keeps tracking the pin through a reset.
module spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk) begin
        chain_q <= {chain_q[STAGES-2:0], d_i};
        prev_q  <= chain_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= chain_q[STAGES-1] & ~prev_q;
            fall_q <= ~chain_q[STAGES-1] & prev_q;
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, 8-bit MSB-first, oversampled in the clk domain.
// Optional macro SPI_SLAVE_UNDERRUN_EN adds the tx_underrun pulse output.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sck,
    input  logic                 mosi,
    input  logic                 cs_n,
    output logic                 miso,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_load,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic [1:0]           state_dbg
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic                 tx_underrun
`endif
);

    logic sck_lvl_unused;
    logic sck_rise;
    logic sck_fall;
    logic cs_n_s;
    logic cs_rise;
    logic cs_fall;

    spi_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sck),
        .q_o    (sck_lvl_unused),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cs_n),
        .q_o    (cs_n_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk) begin
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    spi_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SPI_WIDTH-1:0] rx_shift_q;
    logic [SPI_WIDTH-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic [SPI_WIDTH-1:0] tx_shift_q;
    logic                 miso_q;
    logic [SPI_WIDTH-1:0] hold_q;
    logic                 hold_full_q;

    logic                 frame_start_d;
    logic                 boundary_d;
    logic                 load_pt_d;
    logic [SPI_WIDTH-1:0] next_tx_d;

    // Load point: frame start, or the sck fall that closes a byte with cs_n still low.
    // An empty holding register resends its last byte; a same-cycle tx_load bypasses it.
    always_comb begin
        frame_start_d = (state_q == IDLE) && cs_fall;
        boundary_d    = (state_q == SHIFT) && !cs_n_s && sck_fall && (cnt_q == '0);
        load_pt_d     = frame_start_d || boundary_d;
        if (hold_full_q) begin
            next_tx_d = hold_q;
        end else if (tx_load) begin
            next_tx_d = tx_data;
        end else begin
            next_tx_d = hold_q;
        end
    end

    // Handshake: tx_load is taken only while tx_ready=1; tx_ready drops the cycle after
    // acceptance and returns the cycle after the byte moves into the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARM;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            if (load_pt_d) begin
                hold_full_q <= 1'b0;
                if (!hold_full_q && tx_load) begin
                    hold_q <= tx_data;
                end
            end else if (tx_load && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            case (state_q)
                ARM: begin
                    if (cs_n_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_rise) begin
                        rx_shift_q <= '0;
                    end
                    if (frame_start_d) begin
                        state_q    <= SHIFT;
                        cnt_q      <= '0;
                        tx_shift_q <= next_tx_d;
                        miso_q     <= next_tx_d[SPI_WIDTH-1];
                    end
                end
                SHIFT: begin
                    // Deselect has priority over any sck edge still in flight.
                    if (cs_n_s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        miso_q  <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift_q <= {rx_shift_q[SPI_WIDTH-2:0], mosi_s};
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(SPI_WIDTH - 1)) begin
                            rx_data_q  <= {rx_shift_q[SPI_WIDTH-2:0], mosi_s};
                            rx_valid_q <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (cnt_q == '0) begin
                            tx_shift_q <= next_tx_d;
                            miso_q     <= next_tx_d[SPI_WIDTH-1];
                        end else begin
                            tx_shift_q <= {tx_shift_q[SPI_WIDTH-2:0], 1'b0};
                            miso_q     <= tx_shift_q[SPI_WIDTH-2];
                        end
                    end
                end
                default: state_q <= ARM;
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= load_pt_d && !hold_full_q && !tx_load;
        end
    end
    assign tx_underrun = underrun_q;
`endif

    assign miso      = miso_q;
    assign tx_ready  = !hold_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q == SHIFT);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-0 master driver, a byte-level model of the slave, and a
// per-cycle monitor on the receive side and the deselected outputs.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = SYNC_STAGES + 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       sck     = 1'b0;
    logic       mosi    = 1'b0;
    logic       cs_n    = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       miso;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [1:0] state_dbg;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       tx_underrun;
`endif

    spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .state_dbg (state_dbg)
`ifdef SPI_SLAVE_UNDERRUN_EN
        ,
        .tx_underrun (tx_underrun)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "simulation time limit reached");
    end

    // scoreboard state
    int         checks  = 0;
    int         errors  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] last_rx = 8'h00;
    int         rxv_cnt = 0;
    int         und_cnt = 0;
    int         cs_high = 0;
    logic       mon_en  = 1'b0;

    // byte-level model of the transmit holding register
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    int         m_und  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void m_write(input logic [7:0] d);
        if (!m_full) begin
            m_hold = d;
            m_full = 1'b1;
        end
    endfunction

    function automatic logic [7:0] m_next(input logic coinc, input logic [7:0] d);
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        if (coinc) begin
            m_hold = d;
            return d;
        end
        m_und++;
        return m_hold;
    endfunction

    function automatic void m_reset();
        m_full = 1'b0;
        m_hold = 8'h00;
    endfunction

    // monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                last_rx = 8'h00;
                cs_high = 0;
            end else begin
                if (rx_valid) begin
                    rxv_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected actual=%0h required=none", rx_data);
                    end else begin
                        last_rx = exp_q.pop_front();
                        check("rx_data", rx_data, last_rx);
                    end
                end else begin
                    check("rx_hold", rx_data, last_rx);
                end
                if (cs_n) cs_high++;
                else cs_high = 0;
                if (cs_high > SYNC_STAGES + 3) begin
                    check("miso_idle", miso, 1'b0);
                    check("busy_idle", busy, 1'b0);
                end
`ifdef SPI_SLAVE_UNDERRUN_EN
                if (tx_underrun) und_cnt++;
`endif
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
        m_write(d);
    endtask

    // Full master frame; the last sck fall and the cs_n rise happen together.
    task automatic spi_frame(input int npulses, input logic [7:0] b0, input logic [7:0] b1,
                             input logic coinc, input logic [7:0] cdata,
                             input int mid_at, input logic [7:0] mid_d);
        logic [7:0] outb;
        logic [7:0] inb;
        logic [7:0] expb;
        int         bi;
        inb  = 8'h00;
        expb = 8'h00;
        cs_n = 1'b0;
        for (int p = 0; p < npulses; p++) begin
            bi   = 7 - (p % 8);
            outb = (p < 8) ? b0 : b1;
            mosi = outb[bi];
            if (bi == 7) expb = m_next(coinc && (p == 0), cdata);
            if (p == 0 && coinc) begin
                idle(SYNC_STAGES + 1);
                tx_data = cdata;
                tx_load = 1'b1;
                tick();
                tx_load = 1'b0;
                idle(HALF - SYNC_STAGES - 2);
            end else begin
                idle(HALF);
            end
            if (bi == 0) exp_q.push_back(outb);
            sck = 1'b1;
            inb[bi] = miso;
            if (p == mid_at) begin
                load(mid_d);
                idle(HALF - 1);
            end else begin
                idle(HALF);
            end
            sck = 1'b0;
            if (p == npulses - 1) cs_n = 1'b1;
            if (bi == 0) begin
                check("miso_byte", inb, expb);
                got_q.push_back(inb);
            end
        end
        cs_n = 1'b1;
        idle(3 * HALF);
    endtask

    task automatic raw_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = i[0];
            idle(HALF);
            sck = 1'b1;
            idle(HALF);
            sck = 1'b0;
        end
    endtask

    // stimulus
    int rxv_before;
    int und_before;

    initial begin
        rst = 1'b1;
        idle(4);
        @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_dbg, ARM);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check("rst_underrun", tx_underrun, 1'b0);
`endif
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(4);

        // first frame with a preloaded byte
        load(8'hA5);
        check("t1_ready_low", tx_ready, 1'b0);
        spi_frame(8, 8'h3C, 8'h00, 1'b0, 8'h00, -1, 8'h00);
        check("t1_miso", got_q.pop_front(), 8'hA5);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_rxv_cnt", rxv_cnt, 1);
        check("t1_ready_high", tx_ready, 1'b1);

        // back-to-back bytes, second byte loaded during the first
        load(8'h96);
        spi_frame(16, 8'h11, 8'h22, 1'b0, 8'h00, 2, 8'h5A);
        check("t2_miso0", got_q.pop_front(), 8'h96);
        check("t2_miso1", got_q.pop_front(), 8'h5A);
        check("t2_rx_data", rx_data, 8'h22);
        check("t2_rxv_cnt", rxv_cnt, 3);

        // underrun: two bytes, one load
        und_before = und_cnt;
        load(8'h4D);
        spi_frame(16, 8'h5B, 8'hC8, 1'b0, 8'h00, -1, 8'h00);
        check("t3_miso0", got_q.pop_front(), 8'h4D);
        check("t3_miso1", got_q.pop_front(), 8'h4D);
        check("t3_rxv_cnt", rxv_cnt, 5);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check("t3_underrun", und_cnt - und_before, 1);
`endif

        // abort after five sck pulses, then a clean frame
        rxv_before = rxv_cnt;
        load(8'hE1);
        spi_frame(5, 8'hF0, 8'h00, 1'b0, 8'h00, -1, 8'h00);
        check("t4_no_rxv", rxv_cnt, rxv_before);
        check("t4_miso", miso, 1'b0);
        check("t4_rx_held", rx_data, 8'hC8);
        load(8'h2B);
        spi_frame(8, 8'hE7, 8'h00, 1'b0, 8'h00, -1, 8'h00);
        check("t4_miso_next", got_q.pop_front(), 8'h2B);
        check("t4_rx_next", rx_data, 8'hE7);

        // reset in the middle of a frame
        load(8'h6C);
        cs_n = 1'b0;
        void'(m_next(1'b0, 8'h00));
        raw_pulses(3);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        m_reset();
        rxv_before = rxv_cnt;
        raw_pulses(5);
        idle(HALF);
        check("t5_state_arm", state_dbg, ARM);
        check("t5_busy", busy, 1'b0);
        check("t5_no_rxv", rxv_cnt, rxv_before);
        check("t5_rx_cleared", rx_data, 8'h00);
        cs_n = 1'b1;
        idle(3 * HALF);
        check("t5_state_idle", state_dbg, IDLE);
        spi_frame(8, 8'h81, 8'h00, 1'b0, 8'h00, -1, 8'h00);
        check("t5_miso_after_rst", got_q.pop_front(), 8'h00);
        check("t5_rx_next", rx_data, 8'h81);

        // load handshake
        load(8'h77);
        check("t6_ready_low", tx_ready, 1'b0);
        load(8'hFF);
        check("t6_still_low", tx_ready, 1'b0);
        spi_frame(8, 8'h12, 8'h00, 1'b0, 8'h00, -1, 8'h00);
        check("t6_miso_kept", got_q.pop_front(), 8'h77);
        check("t6_ready_back", tx_ready, 1'b1);
        spi_frame(8, 8'h34, 8'h00, 1'b1, 8'hC3, -1, 8'h00);
        check("t6_miso_coinc", got_q.pop_front(), 8'hC3);
        check("t6_ready_coinc", tx_ready, 1'b1);
        spi_frame(8, 8'h56, 8'h00, 1'b0, 8'h00, -1, 8'h00);
        check("t6_miso_resend", got_q.pop_front(), 8'hC3);
        check("t6_rx_last", rx_data, 8'h56);

        idle(10);
        check("exp_q_drained", exp_q.size(), 0);
        check("rxv_total", rxv_cnt, 10);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check("underrun_total", und_cnt, m_und);
        check("underrun_literal", und_cnt, 3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
